a_encoding_cmd: RTL and testbench

- Host-side command frame generator for the verification accelerator's 16-bit control link; produces exactly the word stream the board-side command decoder consumes.
- Accepts one command request, then emits: header word, data-count word, and N payload words (write) or collects N read-back words (read).
- Provides handshakes toward the host logic, the link transmitter and the read-back path.

---
 rtl/a_encoding_cmd.sv | 273 +++++++++++++++++++++++++++
 tb/tb_a_encoding_cmd.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_encoding_cmd.sv
// a_encoding_cmd: host-side command frame generator for the 16-bit control link.
//
// One accepted command produces one frame. The frame is a header word, a word
// holding the data count N, and then either N payload words sent toward the board
// (write frame) or N read-back words collected from the board (read frame). Every
// frame ends with a quiet gap of at least GAP_CYCLES cycles, so the board-side
// decoder always passes through its standby cycle before the next header.
//
// Parameters
//   TIMEOUT     maximum number of consecutive idle cycles while waiting for a
//               read-back word (16-bit counter)
//   GAP_CYCLES  idle cycles after a frame before the next header (1..15)
//
// Ports
//   clk_ref, rst             clock; synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only while idle)
//   cmd_carte_i, cmd_rw_i,   header fields:
//   cmd_flags_i, cmd_fpga_i,   {stop, fpga, flags, rw, carte}
//   cmd_stop_i
//   cmd_nbr_i                payload word count N
//   wr_data_i/valid/ready    write payload stream from the host
//   tx_data_o/dv_o/ready_i   registered link word stream
//   rd_data_i/rd_valid_i     read-back strobe from the link (no backpressure)
//   rd_data_o/rd_valid_o     read-back word forwarded one cycle later
//   busy_o                   a frame is in progress
//   done_o                   one-cycle pulse: frame completed normally
//   err_o                    one-cycle pulse: N == 0 rejected or read timeout

module a_encoding_cmd #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk_ref,
    input  logic        rst,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_carte_i,
    input  logic        cmd_rw_i,
    input  logic [5:0]  cmd_flags_i,
    input  logic [3:0]  cmd_fpga_i,
    input  logic        cmd_stop_i,
    input  logic [15:0] cmd_nbr_i,

    input  logic [15:0] wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,

    output logic [15:0] tx_data_o,
    output logic        tx_dv_o,
    input  logic        tx_ready_i,

    input  logic [15:0] rd_data_i,
    input  logic        rd_valid_i,
    output logic [15:0] rd_data_o,
    output logic        rd_valid_o,

    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StNbr,
        StWdata,
        StRdata,
        StGap
    } state_e;

    // Gap counter reload values. A rejected command spends one extra cycle in the
    // gap so the error pulse has a cycle of its own before the normal gap.
    localparam logic [4:0] GapLoad    = 5'(GAP_CYCLES - 1);
    localparam logic [4:0] GapLoadRej = 5'(GAP_CYCLES);
    localparam logic [16:0] TimeoutLim = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        rw_q, rw_d;
    logic [15:0] nbr_q, nbr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idle_q, idle_d;
    logic [4:0]  gap_q, gap_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_dv_q, tx_dv_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        cmd_accept;
    logic [15:0] header;
    logic        tx_take;
    logic        wr_window;
    logic        wr_ready;
    logic        wr_take;
    logic        wr_last;
    logic [15:0] cnt_inc;
    logic [16:0] idle_inc;
    logic        timeout_hit;

    assign cmd_accept  = cmd_valid_i && ready_q;
    assign header      = {cmd_stop_i, cmd_fpga_i, cmd_flags_i, cmd_rw_i, cmd_carte_i};
    assign tx_take     = tx_dv_q && tx_ready_i;
    assign cnt_inc     = cnt_q + 16'd1;
    assign idle_inc    = {1'b0, idle_q} + 17'd1;
    assign timeout_hit = (idle_inc >= TimeoutLim);

    // Payload words may already be taken while the count word leaves the link, so
    // the first data word follows the count word without a bubble.
    assign wr_window = (state_q == StWdata) || ((state_q == StNbr) && rw_q);
    assign wr_ready  = wr_window && (!tx_dv_q || tx_ready_i) && (cnt_q < nbr_q);
    assign wr_take   = wr_valid_i && wr_ready;

    // Once all N words have been taken, the output register holds word N.
    assign wr_last = (state_q == StWdata) && tx_take && (cnt_q == nbr_q);

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        nbr_d      = nbr_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_dv_d    = tx_dv_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    rw_d   = cmd_rw_i;
                    nbr_d  = cmd_nbr_i;
                    cnt_d  = 16'd0;
                    idle_d = 16'd0;
                    if (cmd_nbr_i == 16'd0) begin
                        err_d   = 1'b1;
                        gap_d   = GapLoadRej;
                        state_d = StGap;
                    end else begin
                        tx_data_d = header;
                        tx_dv_d   = 1'b1;
                        state_d   = StHdr;
                    end
                end
            end

            StHdr: begin
                if (tx_ready_i) begin
                    tx_data_d = nbr_q;
                    state_d   = StNbr;
                end
            end

            StNbr: begin
                if (tx_ready_i) begin
                    if (rw_q) begin
                        state_d = StWdata;
                        if (wr_take) begin
                            tx_data_d = wr_data_i;
                            cnt_d     = cnt_inc;
                        end else begin
                            tx_dv_d = 1'b0;
                        end
                    end else begin
                        tx_dv_d = 1'b0;
                        idle_d  = 16'd0;
                        state_d = StRdata;
                    end
                end
            end

            StWdata: begin
                if (wr_last) begin
                    tx_dv_d = 1'b0;
                    gap_d   = GapLoad;
                    state_d = StGap;
                end else if (wr_take) begin
                    tx_data_d = wr_data_i;
                    tx_dv_d   = 1'b1;
                    cnt_d     = cnt_inc;
                end else if (tx_take) begin
                    tx_dv_d = 1'b0;
                end
            end

            StRdata: begin
                if (rd_valid_i) begin
                    rd_data_d  = rd_data_i;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_inc;
                    idle_d     = 16'd0;
                    if (cnt_inc == nbr_q) begin
                        done_d  = 1'b1;
                        gap_d   = GapLoad;
                        state_d = StGap;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    gap_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    idle_d = idle_inc[15:0];
                end
            end

            StGap: begin
                if (gap_q == 5'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 5'd1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_dv_d = 1'b0;
            end
        endcase

        // Registered so that cmd_ready_o stays low in the cycle that follows reset.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            rw_q       <= 1'b0;
            nbr_q      <= 16'd0;
            cnt_q      <= 16'd0;
            idle_q     <= 16'd0;
            gap_q      <= 5'd0;
            tx_data_q  <= 16'h0000;
            tx_dv_q    <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rw_q       <= rw_d;
            nbr_q      <= nbr_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_dv_q    <= tx_dv_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign wr_ready_o  = wr_ready;
    assign tx_data_o   = tx_data_q;
    assign tx_dv_o     = tx_dv_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = (state_q != StIdle);
    // Write frames finish in the cycle the link takes the last word; read frames
    // finish together with the registered forward of the last read-back word.
    assign done_o      = done_q || wr_last;
    assign err_o       = err_q;

endmodule

// File: tb/tb_a_encoding_cmd.sv
// Directed bench for a_encoding_cmd: write, backpressured write, read, read
// timeout, N == 0 rejection and reset in mid-frame.

module tb_a_encoding_cmd;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [3:0]  cmd_carte_i = '0;
    logic        cmd_rw_i = 1'b0;
    logic [5:0]  cmd_flags_i = '0;
    logic [3:0]  cmd_fpga_i = '0;
    logic        cmd_stop_i = 1'b0;
    logic [15:0] cmd_nbr_i = '0;
    logic [15:0] wr_data_i = '0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [15:0] tx_data_o;
    logic        tx_dv_o;
    logic        tx_ready_i = 1'b0;
    logic [15:0] rd_data_i = '0;
    logic        rd_valid_i = 1'b0;
    logic [15:0] rd_data_o;
    logic        rd_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    a_encoding_cmd #(
        .TIMEOUT   (8),
        .GAP_CYCLES(2)
    ) dut (
        .clk_ref    (clk_ref),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_carte_i(cmd_carte_i),
        .cmd_rw_i   (cmd_rw_i),
        .cmd_flags_i(cmd_flags_i),
        .cmd_fpga_i (cmd_fpga_i),
        .cmd_stop_i (cmd_stop_i),
        .cmd_nbr_i  (cmd_nbr_i),
        .wr_data_i  (wr_data_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_dv_o    (tx_dv_o),
        .tx_ready_i (tx_ready_i),
        .rd_data_i  (rd_data_i),
        .rd_valid_i (rd_valid_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] carte, input logic rw, input logic [5:0] flags,
                           input logic [3:0] fpga, input logic [15:0] nbr);
        cmd_carte_i = carte;
        cmd_rw_i    = rw;
        cmd_flags_i = flags;
        cmd_fpga_i  = fpga;
        cmd_stop_i  = 1'b0;
        cmd_nbr_i   = nbr;
        cmd_valid_i = 1'b1;
    endtask

    logic [15:0] bp_exp [5];
    logic [15:0] bp_got [8];
    logic [15:0] bp_src [3];

    initial begin
        int          ngot;
        int          idx;
        logic        fin;
        logic        stall;
        logic [15:0] held;

        // ---------------- reset state
        cyc(); cyc(); #1;
        chk("rst_tx_dv", tx_dv_o, 0);
        chk("rst_tx_data", tx_data_o, 16'h0000);
        chk("rst_rd_data", rd_data_o, 16'h0000);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done_err", {done_o, err_o, rd_valid_o, wr_ready_o}, 4'b0000);
        rst = 1'b0;
        cyc(); #1;
        chk("idle_cmd_ready", cmd_ready_o, 1);

        // ---------------- write frame, N=3, full throughput
        set_cmd(4'd1, 1'b1, 6'b000001, 4'd0, 16'd3);
        tx_ready_i = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 16'h00A1;
        #1;
        chk("wr_idle_wr_ready", wr_ready_o, 0);
        cyc(); cmd_valid_i = 1'b0; #1;
        chk("wr_hdr_dv", tx_dv_o, 1);
        chk("wr_hdr_data", tx_data_o, 16'h0031);
        chk("wr_hdr_busy", busy_o, 1);
        chk("wr_hdr_cmd_ready", cmd_ready_o, 0);
        cyc(); #1;
        chk("wr_nbr_data", tx_data_o, 16'h0003);
        chk("wr_nbr_wr_ready", wr_ready_o, 1);
        cyc(); wr_data_i = 16'h00A2; #1;
        chk("wr_d1", {tx_dv_o, tx_data_o}, {1'b1, 16'h00A1});
        chk("wr_d1_done", done_o, 0);
        cyc(); wr_data_i = 16'h00A3; #1;
        chk("wr_d2", {tx_dv_o, tx_data_o}, {1'b1, 16'h00A2});
        cyc(); wr_valid_i = 1'b0; #1;
        chk("wr_d3", {tx_dv_o, tx_data_o}, {1'b1, 16'h00A3});
        chk("wr_d3_done", done_o, 1);
        chk("wr_d3_wr_ready", wr_ready_o, 0);
        cyc(); #1;
        chk("wr_gap1", {tx_dv_o, done_o, busy_o, cmd_ready_o}, 4'b0010);
        cyc(); #1;
        chk("wr_gap2_cmd_ready", cmd_ready_o, 0);
        cyc(); #1;
        chk("wr_back_idle", {cmd_ready_o, busy_o}, 2'b10);

        // ---------------- same write frame, tx_ready_i low on alternate cycles
        bp_exp[0] = 16'h0031; bp_exp[1] = 16'h0003;
        bp_exp[2] = 16'h00C1; bp_exp[3] = 16'h00C2; bp_exp[4] = 16'h00C3;
        bp_src[0] = 16'h00C1; bp_src[1] = 16'h00C2; bp_src[2] = 16'h00C3;
        set_cmd(4'd1, 1'b1, 6'b000001, 4'd0, 16'd3);
        #1;
        cyc(); cmd_valid_i = 1'b0;
        ngot = 0; idx = 0; fin = 1'b0; stall = 1'b0; held = '0;
        for (int k = 0; k < 40 && !fin; k++) begin
            tx_ready_i = (k % 2 == 1);
            wr_valid_i = (idx < 3);
            wr_data_i  = (idx < 3) ? bp_src[idx] : 16'h0000;
            #1;
            if (stall) begin
                chk("bp_hold_dv", tx_dv_o, 1);
                chk("bp_hold_data", tx_data_o, held);
            end
            if (tx_dv_o && !tx_ready_i) begin
                chk("bp_full_wr_ready", wr_ready_o, 0);
                stall = 1'b1;
                held  = tx_data_o;
            end else begin
                stall = 1'b0;
            end
            if (tx_dv_o && tx_ready_i) begin
                if (ngot < 8) bp_got[ngot] = tx_data_o;
                ngot++;
                if (done_o) fin = 1'b1;
            end
            if (wr_valid_i && wr_ready_o) idx++;
            cyc();
        end
        tx_ready_i = 1'b1;
        wr_valid_i = 1'b0;
        chk("bp_done_seen", fin, 1);
        chk("bp_word_count", ngot, 5);
        for (int i = 0; i < 5; i++) chk("bp_word", bp_got[i], bp_exp[i]);
        cyc(); cyc(); #1;
        chk("bp_back_idle", cmd_ready_o, 1);

        // ---------------- read-back strobe outside a read frame is ignored
        rd_valid_i = 1'b1; rd_data_i = 16'hDEAD;
        cyc(); rd_valid_i = 1'b0; #1;
        chk("rd_ignored_idle", {rd_valid_o, rd_data_o}, {1'b0, 16'h0000});

        // ---------------- read frame, N=2
        set_cmd(4'd2, 1'b0, 6'b000100, 4'd5, 16'd2);
        #1;
        cyc(); cmd_valid_i = 1'b0; #1;
        chk("rd_hdr", {tx_dv_o, tx_data_o}, {1'b1, 16'h2882});
        cyc(); #1;
        chk("rd_nbr", {tx_dv_o, tx_data_o}, {1'b1, 16'h0002});
        cyc(); rd_valid_i = 1'b1; rd_data_i = 16'h00B1; #1;
        chk("rd_no_tx", tx_dv_o, 0);
        chk("rd_w1_not_yet", rd_valid_o, 0);
        cyc(); rd_valid_i = 1'b0; #1;
        chk("rd_w1", {rd_valid_o, rd_data_o}, {1'b1, 16'h00B1});
        chk("rd_w1_done", done_o, 0);
        cyc(); rd_valid_i = 1'b1; rd_data_i = 16'h00B2; #1;
        chk("rd_w2_not_yet", rd_valid_o, 0);
        cyc(); rd_valid_i = 1'b0; #1;
        chk("rd_w2", {rd_valid_o, rd_data_o}, {1'b1, 16'h00B2});
        chk("rd_w2_done_err", {done_o, err_o, busy_o}, 3'b101);
        cyc(); cyc(); #1;
        chk("rd_back_idle", cmd_ready_o, 1);

        // ---------------- read timeout, N=4, one word returned, TIMEOUT=8
        set_cmd(4'd2, 1'b0, 6'b000000, 4'd0, 16'd4);
        #1;
        cyc(); cmd_valid_i = 1'b0; #1;
        chk("to_hdr", tx_data_o, 16'h0002);
        cyc(); cyc(); rd_valid_i = 1'b1; rd_data_i = 16'h00B3;
        cyc(); rd_valid_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("to_no_err_yet", {err_o, done_o}, 2'b00);
            cyc();
        end
        #1;
        chk("to_err", {err_o, done_o, rd_valid_o}, 3'b100);
        cyc(); #1;
        chk("to_gap", {err_o, busy_o}, 2'b01);
        cyc(); #1;
        chk("to_back_idle", {cmd_ready_o, busy_o}, 2'b10);

        // ---------------- rejection, N=0
        set_cmd(4'd1, 1'b1, 6'b000001, 4'd0, 16'd0);
        #1;
        cyc(); cmd_valid_i = 1'b0; #1;
        chk("rej_err", {err_o, done_o, tx_dv_o, busy_o}, 4'b1001);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("rej_gap", {err_o, tx_dv_o, busy_o}, 3'b001);
        end
        cyc(); #1;
        chk("rej_back_idle", {cmd_ready_o, busy_o}, 2'b10);

        // ---------------- reset during WDATA after word 1 of 3
        set_cmd(4'd1, 1'b1, 6'b000001, 4'd0, 16'd3);
        wr_valid_i = 1'b1; wr_data_i = 16'h00D1;
        #1;
        cyc(); cmd_valid_i = 1'b0;
        cyc();
        cyc(); wr_data_i = 16'h00D2; rst = 1'b1; #1;
        chk("rst_mid_pre", tx_data_o, 16'h00D1);
        cyc(); #1;
        chk("rst_mid_tx", {tx_dv_o, tx_data_o}, {1'b0, 16'h0000});
        chk("rst_mid_rd", {rd_valid_o, rd_data_o}, {1'b0, 16'h0000});
        chk("rst_mid_ctl", {cmd_ready_o, busy_o, done_o, err_o, wr_ready_o}, 5'b00000);
        rst = 1'b0; wr_valid_i = 1'b0;
        cyc(); #1;
        chk("rst_mid_ready", cmd_ready_o, 1);
        set_cmd(4'd1, 1'b1, 6'b000001, 4'd0, 16'd1);
        wr_valid_i = 1'b1; wr_data_i = 16'h00E1;
        #1;
        cyc(); cmd_valid_i = 1'b0; #1;
        chk("post_rst_hdr", tx_data_o, 16'h0031);
        cyc(); #1;
        chk("post_rst_nbr", tx_data_o, 16'h0001);
        cyc(); wr_valid_i = 1'b0; #1;
        chk("post_rst_data", {tx_dv_o, tx_data_o, done_o}, {1'b1, 16'h00E1, 1'b1});
        cyc(); cyc(); cyc(); #1;
        chk("post_rst_idle", cmd_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
